// File: rtl/s_spi_slave.sv
// SPI mode-0 slave: oversamples sclk/ss_n/mosi, captures one byte per frame into a
// receive buffer and shifts back "SLAVE" (or, with S_SPI_SLAVE_LOOPBACK_EN, the last byte).
module s_spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int MSG_DEPTH   = 64,
  parameter int SYNC_STAGES = 2,
  localparam int IDX_W      = $clog2(MSG_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic [IDX_W-1:0]      rx_index,
  output logic                  frame_err,
  output logic                  busy,
  input  logic [IDX_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync;
  logic [SYNC_STAGES-1:0]  ss_n_sync;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    sclk_prev;
  logic                    ss_n_prev;
  logic                    sclk_s;
  logic                    ss_n_s;
  logic                    mosi_s;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    ss_fall;
  logic                    ss_rise;
  logic [DATA_WIDTH-1:0]   tx_shift;
  logic [DATA_WIDTH-1:0]   rx_shift;
  logic [DATA_WIDTH-1:0]   tx_load;
  logic [3:0]              bit_cnt;
  logic [IDX_W-1:0]        tx_index;
  logic                    commit_ok;
  logic [DATA_WIDTH-1:0]   buffer [MSG_DEPTH];

  // ss_n resets low so a frame already in progress at reset release never looks idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_n_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      ss_n_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
      ss_n_prev <= ss_n_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_n_s    = ss_n_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign ss_fall   = ~ss_n_s & ss_n_prev;
  assign ss_rise   = ss_n_s & ~ss_n_prev;

  function automatic logic [DATA_WIDTH-1:0] msg_byte(input logic [IDX_W-1:0] idx);
    logic [7:0] ch;
    case (idx)
      IDX_W'(0): ch = 8'h53;
      IDX_W'(1): ch = 8'h4C;
      IDX_W'(2): ch = 8'h41;
      IDX_W'(3): ch = 8'h56;
      IDX_W'(4): ch = 8'h45;
      default:   ch = 8'h00;
    endcase
    return DATA_WIDTH'(ch);
  endfunction

`ifdef S_SPI_SLAVE_LOOPBACK_EN
  assign tx_load = rx_data;
`else
  assign tx_load = msg_byte(tx_index);
`endif

  assign commit_ok = (state == COMMIT) && (bit_cnt == 4'(DATA_WIDTH)) && !clear;
  assign busy      = (state == SHIFT) || (state == COMMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_IDLE;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      rx_index  <= '0;
      tx_index  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso      <= (state == SHIFT) ? tx_shift[DATA_WIDTH-1] : 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (ss_n_s) state <= IDLE;
        end
        IDLE: begin
          if (ss_fall && !clear) begin
            tx_shift <= tx_load;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (clear) begin
            state <= WAIT_IDLE;
          end else if (ss_rise) begin
            state <= COMMIT;
          end else begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
              if (bit_cnt != 4'd15) bit_cnt <= bit_cnt + 4'd1;
            end
            if (sclk_fall) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (commit_ok) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            rx_index <= rx_index + 1'b1;
            tx_index <= tx_index + 1'b1;
          end else if (!clear) begin
            frame_err <= 1'b1;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
      if (clear) begin
        rx_index <= '0;
        tx_index <= '0;
      end
    end
  end

  // A write to slot 0 wipes every other slot so each new message starts clean.
  for (genvar gi = 0; gi < MSG_DEPTH; gi++) begin : g_entry
    logic [DATA_WIDTH-1:0] entry_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry_reg <= '0;
      end else if (clear) begin
        entry_reg <= '0;
      end else if (commit_ok) begin
        if (rx_index == IDX_W'(gi)) entry_reg <= rx_shift;
        else if (rx_index == '0)    entry_reg <= '0;
      end
    end
    assign buffer[gi] = entry_reg;
  end

  assign rd_data = buffer[rd_addr];

endmodule
